// File: rtl/ad_reg_pkg.sv
// Shared types and transfer-register bit positions for the master/shadow register bank.
package ad_reg_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, XFER} xfer_state_t;

  localparam int XFER_REQ_BIT   = 0;
  localparam int XFER_TOCLR_BIT = 1;

endpackage

// File: rtl/ad_xfer_fsm.sv
// Transfer sequencer: arms on request, fires on immediate/sync/timeout, and keeps the sticky timeout flag.
module ad_xfer_fsm #(
  parameter int SYNC_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic ctl_wr,
  input  logic req,
  input  logic toclr,
  input  logic sync_mode,
  input  logic sync_in,
  output logic xfer_stb,
  output logic busy,
  output logic done,
  output logic timeout
);
  import ad_reg_pkg::*;

  localparam int CNT_W = (SYNC_TIMEOUT > 0) ? $clog2(SYNC_TIMEOUT + 1) : 1;

  xfer_state_t state_q, state_d;
  logic        tmo_hit;
  logic        force_go;
  logic        timeout_q;

  generate
    if (SYNC_TIMEOUT > 0) begin : g_tmo
      localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(SYNC_TIMEOUT - 1);
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (reset || (state_q != ARMED)) cnt_q <= '0;
        else                             cnt_q <= cnt_q + 1'b1;
      end

      assign tmo_hit = (state_q == ARMED) && (cnt_q == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // A cancel wins over a same-cycle fire condition; a forced fire is one not explained by mode or sync.
  always_comb begin
    state_d  = state_q;
    xfer_stb = 1'b0;
    force_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctl_wr && req) state_d = ARMED;
      end
      ARMED: begin
        if (ctl_wr && !req) begin
          state_d = IDLE;
        end else if (!sync_mode || sync_in || tmo_hit) begin
          state_d  = XFER;
          xfer_stb = 1'b1;
          force_go = sync_mode && !sync_in;
        end
      end
      XFER:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (force_go)             timeout_q <= 1'b1;
      else if (ctl_wr && toclr) timeout_q <= 1'b0;
    end
  end

  assign busy    = (state_q == ARMED);
  assign done    = (state_q == XFER);
  assign timeout = timeout_q;

endmodule

// File: rtl/ad_shadow_regbank.sv
// Master/shadow configuration register bank with atomic, optionally frame-synced transfer.
// Optional feature macro: AD_SHADOW_READBACK_EN (upper-half reads return shadow contents).
module ad_shadow_regbank #(
  parameter int                         ADDR_W       = 13,
  parameter int                         DATA_W       = 8,
  parameter int                         NUM_REGS     = 16,
  parameter logic [ADDR_W-1:0]          XFER_ADDR    = ADDR_W'('h0FF),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL    = '0,
  parameter int                         SYNC_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            Addr,
  input  logic [DATA_W-1:0]            wrData,
  output logic [DATA_W-1:0]            rdData,
  input  logic                         sync_mode,
  input  logic                         sync_in,
  output logic [NUM_REGS*DATA_W-1:0]   shadow_data,
  output logic                         xfer_busy,
  output logic                         xfer_done,
  output logic                         xfer_timeout
);
  import ad_reg_pkg::*;

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] master_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_data_p1;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              ctl_wr;
  logic              xfer_stb;
  logic              busy_w;
  logic              done_w;
  logic              timeout_w;

  assign idx      = Addr[IDX_W-1:0];
  assign in_range = (Addr < NUM_REGS_A);
  assign ctl_wr   = write && (Addr == XFER_ADDR);

  ad_xfer_fsm #(
    .SYNC_TIMEOUT (SYNC_TIMEOUT)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .ctl_wr    (ctl_wr),
    .req       (wrData[XFER_REQ_BIT]),
    .toclr     (wrData[XFER_TOCLR_BIT]),
    .sync_mode (sync_mode),
    .sync_in   (sync_in),
    .xfer_stb  (xfer_stb),
    .busy      (busy_w),
    .done      (done_w),
    .timeout   (timeout_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) master_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else if (write && in_range) begin
      master_q[idx] <= wrData;
    end
  end

  // Shadow samples master before any same-edge host write lands, so that write waits for the next transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else if (xfer_stb) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= master_q[i];
    end
  end

  always_comb begin
    rd_d = '0;
    if (in_range) begin
      rd_d = master_q[idx];
    end else if (Addr == XFER_ADDR) begin
      rd_d[XFER_REQ_BIT]   = busy_w;
      rd_d[XFER_TOCLR_BIT] = timeout_w;
    end
`ifdef AD_SHADOW_READBACK_EN
    else if (Addr[ADDR_W-1] && ({1'b0, Addr[ADDR_W-2:0]} < NUM_REGS_A)) begin
      rd_d = shadow_q[idx];
    end
`endif
  end

  // Read data stage
  always_ff @(posedge clk) begin
    if (reset) rd_data_p1 <= '0;
    else       rd_data_p1 <= rd_d;
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign shadow_data[g*DATA_W +: DATA_W] = shadow_q[g];
    end
  endgenerate

  assign rdData       = rd_data_p1;
  assign xfer_busy    = busy_w;
  assign xfer_done    = done_w;
  assign xfer_timeout = timeout_w;

endmodule
